// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/line types and the memory arbiter state encoding.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
endpackage

// File: rtl/cache_arbiter_req_reg.sv
// arb_req_reg: latches the granted request (op, line-aligned address, write data).
module arb_req_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_load,
  input  logic     i_read,
  input  logic     i_write,
  input  lc3b_word i_addr,
  input  lc3b_line i_wdata,
  output logic     o_read,
  output logic     o_write,
  output lc3b_word o_addr,
  output lc3b_line o_wdata
);
  logic     r_read, r_write;
  lc3b_word r_addr;
  lc3b_line r_wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_read  <= i_read;
      r_write <= i_write;
      r_addr  <= i_addr & 16'hFFF0;
      r_wdata <= i_wdata;
    end
  end
  assign o_read  = r_read;
  assign o_write = r_write;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one pmem line port between I-cache and D-cache, D priority.
// Optional I-cache anti-starvation counter when CACHE_ARB_STARVE_EN is defined.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_pmem_read,
  input  lc3b_word i_pmem_address,
  output lc3b_line i_pmem_rdata,
  output logic     i_pmem_resp,
  input  logic     d_pmem_read,
  input  logic     d_pmem_write,
  input  lc3b_word d_pmem_address,
  input  lc3b_line d_pmem_wdata,
  output lc3b_line d_pmem_rdata,
  output logic     d_pmem_resp,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);
  arb_state_t r_state, w_next;
  logic       w_idle, w_d_req, w_i_win, w_grant_i, w_grant_d, w_ld_write;
  logic       w_op_read, w_op_write;
  assign w_idle  = r_state == ARB_IDLE;
  assign w_d_req = d_pmem_read | d_pmem_write;
`ifdef CACHE_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;
  assign w_i_win = i_pmem_read & (~w_d_req | (r_starve_cnt == CW'(STARVE_LIMIT)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_starve_cnt <= '0;
    else if (w_grant_i) r_starve_cnt <= '0;
    else if (w_grant_d && i_pmem_read && r_starve_cnt != CW'(STARVE_LIMIT))
      r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`else
  // A zero limit means the I-cache always wins, matching the counter build.
  assign w_i_win = i_pmem_read & (~w_d_req | (STARVE_LIMIT == 0));
`endif
  assign w_grant_i  = w_idle & w_i_win;
  assign w_grant_d  = w_idle & w_d_req & ~w_i_win;
  assign w_ld_write = w_grant_d & d_pmem_write;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_idle) w_next = w_grant_i ? ARB_SERVE_I : (w_grant_d ? ARB_SERVE_D : ARB_IDLE);
    else if (pmem_resp) w_next = ARB_IDLE;
  end
  arb_req_reg u_req (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_grant_i | w_grant_d),
    .i_read (~w_ld_write),
    .i_write(w_ld_write),
    .i_addr (w_grant_i ? i_pmem_address : d_pmem_address),
    .i_wdata(w_ld_write ? d_pmem_wdata : '0),
    .o_read (w_op_read),
    .o_write(w_op_write),
    .o_addr (pmem_address),
    .o_wdata(pmem_wdata)
  );
  assign pmem_read    = ~w_idle & w_op_read;
  assign pmem_write   = ~w_idle & w_op_write;
  assign i_pmem_resp  = pmem_resp & (r_state == ARB_SERVE_I);
  assign d_pmem_resp  = pmem_resp & (r_state == ARB_SERVE_D);
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: random I/D traffic against a transaction-level arbitration model.
module tb_cache_arbiter;
  import lc3b_types::*;
  localparam int STARVE_LIMIT = 4;
`ifdef CACHE_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic i_pmem_read = 0, d_pmem_read = 0, d_pmem_write = 0, pmem_resp = 0;
  lc3b_word i_pmem_address = '0, d_pmem_address = '0;
  lc3b_line d_pmem_wdata = '0, pmem_rdata = '0;
  lc3b_line i_pmem_rdata, d_pmem_rdata, pmem_wdata;
  logic i_pmem_resp, d_pmem_resp, pmem_read, pmem_write;
  lc3b_word pmem_address;

  cache_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_d;
    bit       rd;
    bit       wr;
    lc3b_word addr;
    lc3b_line wdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;
  int n_chk = 0, n_fail = 0;
  bit mon_en = 0, in_txn = 0;
  bit m_busy = 0;
  int m_cnt = 0;
  int i_gap = 0, d_gap = 0, mem_wait = 0;
  int n_i_grants = 0, n_d_grants = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: a new transaction appears when a strobe rises outside a transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((pmem_read | pmem_write) && !in_txn) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL grant_unexpected: got op r=%b w=%b addr %h, expected no grant", pmem_read, pmem_write, pmem_address);
          cur = '{is_d: pmem_write, rd: pmem_read, wr: pmem_write, addr: pmem_address, wdata: pmem_wdata};
        end else begin
          cur = exp_q.pop_front();
          chk("grant_op", {pmem_read, pmem_write}, {cur.rd, cur.wr});
          chk("grant_addr", pmem_address, cur.addr);
          if (cur.wr) chk("grant_wdata", pmem_wdata, cur.wdata);
        end
        in_txn = 1;
      end
      if (in_txn) chk("addr_hold", pmem_address, cur.addr);
      if (pmem_resp) begin
        chk("i_resp", i_pmem_resp, in_txn && !cur.is_d);
        chk("d_resp", d_pmem_resp, in_txn && cur.is_d);
        if (in_txn) chk(cur.is_d ? "d_rdata" : "i_rdata", cur.is_d ? d_pmem_rdata : i_pmem_rdata, pmem_rdata);
        in_txn = 0;
      end else chk("resp_quiet", {i_pmem_resp, d_pmem_resp}, 2'b00);
    end
  end

  function automatic lc3b_line rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input bit gen);
    logic si, sd, ir, dr, iw;
    @(negedge clk);
    si = i_pmem_resp;
    sd = d_pmem_resp;
    @(posedge clk);
    // Reference model: one outstanding transaction, decided at each idle edge.
    if (m_busy) begin
      if (pmem_resp) m_busy = 0;
    end else begin
      ir = i_pmem_read;
      dr = d_pmem_read | d_pmem_write;
      iw = ir && (!dr || (STARVE_ON && m_cnt == STARVE_LIMIT));
      if (iw) begin
        exp_q.push_back('{is_d: 0, rd: 1, wr: 0, addr: {i_pmem_address[15:4], 4'h0}, wdata: '0});
        m_cnt = 0;
        m_busy = 1;
        n_i_grants++;
      end else if (dr) begin
        exp_q.push_back('{is_d: 1, rd: !d_pmem_write, wr: d_pmem_write,
                          addr: {d_pmem_address[15:4], 4'h0}, wdata: d_pmem_wdata});
        if (ir && m_cnt < STARVE_LIMIT) m_cnt++;
        m_busy = 1;
        n_d_grants++;
      end
    end
    #1;
    if (pmem_resp) begin
      pmem_resp = 0;
      mem_wait = $urandom_range(0, 2);
    end else if (pmem_read | pmem_write) begin
      if (mem_wait == 0) begin
        pmem_resp = 1;
        pmem_rdata = rnd_line();
      end else mem_wait--;
    end else if ($urandom_range(0, 15) == 0) begin
      pmem_resp = 1;
      pmem_rdata = rnd_line();
    end
    if (i_pmem_read) begin
      if (si) begin
        i_pmem_read = 0;
        i_gap = $urandom_range(0, 2);
      end else if ($urandom_range(0, 3) == 0) i_pmem_address = lc3b_word'($urandom);
    end else if (i_gap > 0) i_gap--;
    else if (gen && $urandom_range(0, 1) == 1) begin
      i_pmem_read = 1;
      i_pmem_address = lc3b_word'($urandom);
    end
    if (d_pmem_read | d_pmem_write) begin
      if (sd) begin
        d_pmem_read = 0;
        d_pmem_write = 0;
        d_gap = $urandom_range(0, 1);
      end else if ($urandom_range(0, 3) == 0) begin
        d_pmem_address = lc3b_word'($urandom);
        d_pmem_wdata = rnd_line();
      end
    end else if (d_gap > 0) d_gap--;
    else if (gen && $urandom_range(0, 2) != 0) begin
      int r;
      r = $urandom_range(0, 9);
      d_pmem_write = (r < 4) || (r == 9);
      d_pmem_read = (r >= 4);
      d_pmem_address = lc3b_word'($urandom);
      d_pmem_wdata = rnd_line();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
    chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("rst_addr", pmem_address, 16'h0);
    chk("rst_wdata", pmem_wdata, 128'h0);
    @(negedge clk);
    rst = 0;
    mon_en = 1;
    for (int c = 0; c < 4000; c++) step(c < 3400);
    n_chk++;
    if (exp_q.size() != 0 || in_txn || i_pmem_read || d_pmem_read || d_pmem_write) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, in_txn=%0b, expected all transactions complete", exp_q.size(), in_txn);
    end
    n_chk++;
    if (n_i_grants < 10 || n_d_grants < 10) begin
      n_fail++;
      $display("FAIL traffic_mix: got %0d I and %0d D grants, expected at least 10 each", n_i_grants, n_d_grants);
    end
    mon_en = 0;
    pmem_resp = 0;
    @(posedge clk);
    #1;
    i_pmem_read = 1;
    i_pmem_address = 16'h1234;
    @(posedge clk);
    #1;
    chk("iread_strobe", {pmem_read, pmem_write}, 2'b10);
    chk("iread_addr", pmem_address, 16'h1230);
    pmem_resp = 1;
    pmem_rdata = {16{8'hA5}};
    #1;
    chk("iread_resp", {i_pmem_resp, d_pmem_resp}, 2'b10);
    chk("iread_rdata", i_pmem_rdata, {16{8'hA5}});
    @(posedge clk);
    #1;
    i_pmem_read = 0;
    pmem_resp = 0;
    chk("iread_done", {pmem_read, pmem_write}, 2'b00);
    d_pmem_write = 1;
    d_pmem_address = 16'h8007;
    d_pmem_wdata = {4{32'hDEADBEEF}};
    @(posedge clk);
    #1;
    d_pmem_write = 0;
    chk("dwr_strobe", {pmem_read, pmem_write}, 2'b01);
    chk("dwr_addr", pmem_address, 16'h8000);
    chk("dwr_wdata", pmem_wdata, {4{32'hDEADBEEF}});
    #2;
    rst = 1;
    #1;
    chk("rst_async_strobe", pmem_write, 1'b0);
    chk("rst_async_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("rst_async_addr", pmem_address, 16'h0);
    @(negedge clk);
    rst = 0;
    pmem_resp = 1;
    #1;
    chk("stray_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk);
    #1;
    pmem_resp = 0;
    chk("post_rst_idle", {pmem_read, pmem_write}, 2'b00);
    @(posedge clk);
    #1;
    chk("stray_no_grant", {pmem_read, pmem_write}, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates the single physical-memory port between the instruction cache and the data cache, which share one 128-bit line-granular pmem interface. Sits directly downstream of both cache datapaths/controllers and upstream of physical memory. It accepts one line read or write per transaction, latches the winning request and drives it to memory until `pmem_resp`. It then routes the response back to the granted cache only.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive D-cache grants, taken while an I-cache request is pending, after which the I-cache wins the next arbitration.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_pmem_read`  in  1  I-cache line read request.
- `i_pmem_address`  in  16  I-cache line address (`lc3b_word`, bits [3:0] ignored).
- `i_pmem_rdata`  out  128  line data to I-cache.
- `i_pmem_resp`  out  1  I-cache transaction complete.
- `d_pmem_read`  in  1  D-cache line read request.
- `d_pmem_write`  in  1  D-cache line write-back request.
- `d_pmem_address`  in  16  D-cache line address.
- `d_pmem_wdata`  in  128  D-cache write-back line.
- `d_pmem_rdata`  out  128  line data to D-cache.
- `d_pmem_resp`  out  1  D-cache transaction complete.
- `pmem_read`  out  1  memory read strobe.
- `pmem_write`  out  1  memory write strobe.
- `pmem_address`  out  16  memory line address, bits [3:0] forced to 0.
- `pmem_wdata`  out  128  memory write line.
- `pmem_rdata`  in  128  memory read line.
- `pmem_resp`  in  1  memory transaction complete.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`.
- In `IDLE`, requests are sampled:
  - D request (`d_pmem_read | d_pmem_write`) only: go to `SERVE_D`.
  - I request only: go to `SERVE_I`.
  - Both: D wins, except when starvation override is active (see Configuration).
- On grant, the arbiter latches into registers:
  - op (read/write);
  - address with [3:0] zeroed;
  - wdata (D writes only).
- In `SERVE_x`, `pmem_read`/`pmem_write` and address/wdata are driven from the latched registers. Client inputs are ignored until the transaction completes.
- `d_pmem_read` and `d_pmem_write` both high is illegal. If it happens, the write wins.
- Response routing:
  - `x_pmem_resp = pmem_resp & (state == SERVE_x)`.
  - Both `x_pmem_rdata` outputs are driven directly from `pmem_rdata`.
- On `pmem_resp` in `SERVE_x`, the next state is `IDLE`. Strobes drop on the following edge.
- `pmem_resp` received in `IDLE` is ignored and produces no client resp.
- Reset values:
  - state `IDLE`;
  - `pmem_read`/`pmem_write`/both resps 0;
  - latched address/wdata 0;
  - starvation counter 0.
- Reset asserted mid-transaction aborts it immediately (asynchronously) with no client resp.

## Timing
- Grant latency: a request first seen in `IDLE` at edge N produces `pmem_read`/`pmem_write` during cycle N+1.
- Response latency: zero. Client resp and rdata are combinational in the same cycle as `pmem_resp`.
- After a completion, the arbiter spends at least one `IDLE` cycle before the next grant. Clients must drop their request the cycle after their resp, which the cache controllers already do.
- Minimum transaction length: 2 cycles (grant cycle plus the `pmem_resp` cycle).
- Back-to-back I/D traffic alternates at roughly 1 IDLE cycle of overhead per transaction.

## Configuration
- Macro: `CACHE_ARB_STARVE_EN`.
- Defined:
  - A counter `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`) increments on each D grant made while `i_pmem_read` is high, saturating at `STARVE_LIMIT`.
  - The counter clears on any I grant.
  - When `starve_cnt == STARVE_LIMIT` and both clients request, I wins.
- Undefined:
  - The counter is not built.
  - Pure fixed priority, D over I.

## Structure
- Shared package `lc3b_types`:
  - `lc3b_word` (existing);
  - add `lc3b_line` (128-bit);
  - add an enum `arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}`.
- One module with an internal FSM is sufficient.
- The request-latch registers are a natural sub-module: `arb_req_reg` (address+wdata+op register with a load enable).

## Test plan
- I read alone: `i_pmem_read=1`, address `16'h1234`. Cycle after: `pmem_read=1`, `pmem_address=16'h1230`. When memory returns `pmem_resp` with `pmem_rdata=128'hA5..`, `i_pmem_resp=1` that cycle, `d_pmem_resp=0`.
- D write alone: `d_pmem_write=1`, address `16'h8007`, wdata `128'hDEAD..`. Expect `pmem_write=1`, `pmem_address=16'h8000`, `pmem_wdata` matching, and `d_pmem_resp` pulse on `pmem_resp`.
- Simultaneous: both request in the same cycle with the macro undefined. D is served first, then I after one IDLE cycle. I address is unchanged even if the client alters it mid-D transaction.
- Starvation (macro defined, `STARVE_LIMIT=4`): I held high while D re-requests continuously. Expect exactly 4 D grants, then an I grant, then `starve_cnt=0`.
- Reset mid-transaction: assert `rst` during `SERVE_D` with `pmem_write=1`. `pmem_write` drops without a clock edge, no resp is issued, and the state is `IDLE` after release.
- Stray `pmem_resp` in `IDLE`: both client resps stay 0 and no state change occurs.
